decode_stage: RTL and testbench
===============================

// Module: decode_stage
// PURPOSE
//  Decode stage feeding the ALU. Accepts fetched RV32I instructions (OP, OP-IMM, LUI, AUIPC)
//  over a valid/ready handshake and reads rs1/rs2 from the register file.
//  Produces a registered {alu_opcode_t, op1, op2, rd} bundle for the execute stage.
//  Unsupported encodings pass through flagged illegal.
// PARAMETERS
//  REG_READY  1  1: o_in_ready driven from a flop (2-entry skid buffer); 0: o_in_ready = !o_out_valid | i_out_ready
// PORTS
//  i_clk         in   1   clock, rising edge
//  i_rst_n       in   1   asynchronous reset, active low
//  i_flush       in   1   sync flush: drop all held entries, ignore input this cycle
//  i_in_valid    in   1   instruction valid from fetch
//  o_in_ready    out  1   stage can accept
//  i_instr       in   32  instruction word
//  i_pc          in   32  instruction address
//  o_rs1_addr    out  5   comb = i_instr[19:15], to regfile
//  o_rs2_addr    out  5   comb = i_instr[24:20], to regfile
//  i_rs1_data    in   32  regfile read data, same cycle as accept
//  i_rs2_data    in   32  regfile read data, same cycle as accept
//  o_out_valid   out  1   bundle valid to execute
//  i_out_ready   in   1   execute accepts
//  o_alu_op      out  alu_opcode_t  ALU operation
//  o_op1/o_op2   out  32  ALU operands
//  o_rd_addr     out  5   destination register
//  o_rd_we       out  1   write enable; 0 when rd==x0 or illegal
//  o_pc          out  32  pc of the bundle
//  o_illegal     out  1   encoding unsupported
// BEHAVIOUR
//  Reset (async, i_rst_n=0): o_out_valid=0, all bundle outputs 0, o_alu_op=ALU_ADD, o_in_ready=1
//    (REG_READY=1: flop reset value 1); skid buffer emptied. Reset mid-operation discards all entries.
//  Accept on i_in_valid & o_in_ready & !i_flush. Transfer out on o_out_valid & i_out_ready.
//  Latency: 1 cycle, accept edge to o_out_valid. Throughput: 1/cycle with i_out_ready held 1.
//  Stall: bundle outputs hold stable while o_out_valid & !i_out_ready. Order preserved.
//  REG_READY=1 skid FSM: EMPTY -> ONE on accept. ONE -> TWO on accept without transfer;
//    o_in_ready=0 from the next cycle. ONE -> EMPTY on transfer without accept.
//    TWO -> ONE on transfer; o_in_ready=1 next cycle. Accept and transfer on the same edge keep the state.
//  i_flush: all states -> EMPTY next edge; o_out_valid=0 next cycle. The input offered in the flush cycle is dropped.
//    Flush wins over simultaneous accept/transfer.
//  Decode (opcode = instr[6:0]):
//    0110011 OP: op1=rs1, op2=rs2; f3 selects the op; f7=0100000 legal only on f3=000 (SUB) and 101 (SRA);
//      any f7 other than 0000000/0100000 (e.g. M-ext) is illegal.
//    0010011 OP-IMM: op1=rs1, op2=sext(instr[31:20]); no SUBI.
//      SLLI needs f7=0000000. SRLI/SRAI need f7 0000000/0100000.
//      For shifts, op2={27'b0, instr[24:20]}.
//    0110111 LUI: op1=0, op2={instr[31:12], 12'b0}, ALU_ADD.
//    0010111 AUIPC: op1=pc, op2={instr[31:12], 12'b0}, ALU_ADD.
//    Other opcodes are illegal.
//  Illegal bundle: o_illegal=1, o_rd_we=0, ALU_ADD, op1=op2=0. It still flows through the handshake.
//  All arithmetic is 32-bit; immediates are sign-extended from bit 31. No hazard detection or forwarding here.
// STRUCTURE
//  alu.svh: alu_opcode_t (shared). New package entries in decode_pkg:
//    RV opcode constants (OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC);
//    decoded_t struct {alu_op, op1, op2, rd_addr, rd_we, pc, illegal}.
//  Combinational decode function/always_comb producing decoded_t.
//  Sub-module pipe_skid_buf #(type T=decoded_t) owns the handshake and flush; generate-selects on REG_READY.
// TESTING
//  1. ADDI x1,x0,5 (0x00500093), rs1_data=0 -> next cycle ALU_ADD, op1=0, op2=5, rd=1, we=1, illegal=0.
//  2. SUB x3,x1,x2 (0x402081B3), rs1=10, rs2=3 -> ALU_SUB, op1=10, op2=3, rd=3.
//  3. SRAI x5,x5,4 (0x4042D293), rs1=0x80000000 -> ALU_SRA, op2=4.
//     AUIPC x1,0x12345 (0x12345097) at pc=0x100 -> ALU_ADD, op1=0x100, op2=0x12345000.
//  4. REG_READY=1, i_out_ready=0, 3 instrs offered back-to-back -> 2 accepted, o_in_ready=0 after 2nd, outputs stable;
//     release -> drain in order, 3rd accepted.
//  5. MUL (0x02208033) and opcode 0x7F -> illegal=1, we=0. ADDI x0 -> we=0, illegal=0.
//  6. i_flush while stalled with 2 held -> o_out_valid=0 next cycle, none emitted.
//     i_rst_n pulse mid-stream -> all outputs at reset values immediately.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared types for the decode stage: ALU opcodes, RV32I major opcodes, decoded bundle.
// Pure declarations; no logic.
package decode_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_opcode_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_opcode_t alu_op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [31:0] pc;
    logic        illegal;
  } decoded_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Valid/ready pipeline register for an arbitrary payload; 1-cycle latency, flush drops everything held.
// REG_READY=1: 2-entry skid with flopped ready; REG_READY=0: single stage, ready = !valid | out_ready.
module pipe_skid_buf
  import decode_pkg::*;
#(
  parameter type T         = decoded_t,
  parameter bit  REG_READY = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_flush,
  input  logic i_in_valid,
  output logic o_in_ready,
  input  T     i_data,
  output logic o_out_valid,
  input  logic i_out_ready,
  output T     o_data
);

  if (REG_READY) begin : g_skid
    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

    skid_state_t state_q, state_d;
    T            head_q, tail_q;
    logic        ready_q;
    logic        accept, xfer;

    assign accept = i_in_valid & ready_q & ~i_flush;
    assign xfer   = (state_q != EMPTY) & i_out_ready & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        state_q <= EMPTY;
        ready_q <= 1'b1;
      end else begin
        state_q <= state_d;
        ready_q <= (state_d != TWO);
      end
    end

    always_comb begin
      state_d = state_q;
      if (i_flush) begin
        state_d = EMPTY;
      end else begin
        case (state_q)
          EMPTY:   if (accept) state_d = ONE;
          ONE:     if (accept && !xfer) state_d = TWO;
                   else if (!accept && xfer) state_d = EMPTY;
          TWO:     if (xfer) state_d = ONE;
          default: state_d = EMPTY;
        endcase
      end
    end

    // head_q is always the entry on the output; tail_q only fills while head stalls.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        head_q <= '0;
        tail_q <= '0;
      end else if (state_q == TWO) begin
        if (xfer) head_q <= tail_q;
      end else if (accept && (state_q == EMPTY || xfer)) begin
        head_q <= i_data;
      end else if (accept) begin
        tail_q <= i_data;
      end
    end

    assign o_in_ready  = ready_q;
    assign o_out_valid = (state_q != EMPTY);
    assign o_data      = head_q;
  end else begin : g_pipe
    logic valid_q;
    T     data_q;
    logic accept;

    assign o_in_ready = ~valid_q | i_out_ready;
    assign accept     = i_in_valid & o_in_ready & ~i_flush;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        valid_q <= 1'b0;
        data_q  <= '0;
      end else if (i_flush) begin
        valid_q <= 1'b0;
      end else if (accept) begin
        valid_q <= 1'b1;
        data_q  <= i_data;
      end else if (i_out_ready) begin
        valid_q <= 1'b0;
      end
    end

    assign o_out_valid = valid_q;
    assign o_data      = data_q;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I integer decode (OP, OP-IMM, LUI, AUIPC) into ALU operands; 1-cycle latency, registered outputs.
// Backpressure via valid/ready through pipe_skid_buf; unsupported encodings flow through flagged illegal.
module decode_stage
  import decode_pkg::*;
#(
  parameter bit REG_READY = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_flush,
  input  logic        i_in_valid,
  output logic        o_in_ready,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [4:0]  o_rs1_addr,
  output logic [4:0]  o_rs2_addr,
  input  logic [31:0] i_rs1_data,
  input  logic [31:0] i_rs2_data,
  output logic        o_out_valid,
  input  logic        i_out_ready,
  output alu_opcode_t o_alu_op,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  output logic [4:0]  o_rd_addr,
  output logic        o_rd_we,
  output logic [31:0] o_pc,
  output logic        o_illegal
);

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [31:0] imm_i, imm_u, shamt;
  logic        legal;
  decoded_t    dec, out;

  assign o_rs1_addr = i_instr[19:15];
  assign o_rs2_addr = i_instr[24:20];

  assign opc   = i_instr[6:0];
  assign f3    = i_instr[14:12];
  assign f7    = i_instr[31:25];
  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_u = {i_instr[31:12], 12'b0};
  assign shamt = {27'b0, i_instr[24:20]};

  always_comb begin
    dec         = '0;
    dec.alu_op  = ALU_ADD;
    dec.pc      = i_pc;
    dec.rd_addr = i_instr[11:7];
    legal       = 1'b1;
    case (opc)
      OPC_OP: begin
        dec.op1 = i_rs1_data;
        dec.op2 = i_rs2_data;
        case (f3)
          3'b000:  dec.alu_op = (f7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          3'b001:  dec.alu_op = ALU_SLL;
          3'b010:  dec.alu_op = ALU_SLT;
          3'b011:  dec.alu_op = ALU_SLTU;
          3'b100:  dec.alu_op = ALU_XOR;
          3'b101:  dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
        if (f7 == F7_ALT) legal = (f3 == 3'b000) || (f3 == 3'b101);
        else              legal = (f7 == F7_BASE);
      end
      OPC_OP_IMM: begin
        dec.op1 = i_rs1_data;
        dec.op2 = imm_i;
        case (f3)
          3'b000: dec.alu_op = ALU_ADD;
          3'b001: begin
            dec.alu_op = ALU_SLL;
            dec.op2    = shamt;
            legal      = (f7 == F7_BASE);
          end
          3'b010: dec.alu_op = ALU_SLT;
          3'b011: dec.alu_op = ALU_SLTU;
          3'b100: dec.alu_op = ALU_XOR;
          3'b101: begin
            dec.alu_op = (f7 == F7_ALT) ? ALU_SRA : ALU_SRL;
            dec.op2    = shamt;
            legal      = (f7 == F7_BASE) || (f7 == F7_ALT);
          end
          3'b110:  dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
      end
      OPC_LUI: begin
        dec.op1 = '0;
        dec.op2 = imm_u;
      end
      OPC_AUIPC: begin
        dec.op1 = i_pc;
        dec.op2 = imm_u;
      end
      default: legal = 1'b0;
    endcase
    // Illegal bundles carry no operands so execute can treat them as a harmless ADD.
    if (!legal) begin
      dec.alu_op = ALU_ADD;
      dec.op1    = '0;
      dec.op2    = '0;
    end
    dec.illegal = ~legal;
    dec.rd_we   = legal && (dec.rd_addr != 5'd0);
  end

  pipe_skid_buf #(
    .T         (decoded_t),
    .REG_READY (REG_READY)
  ) u_skid (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_flush     (i_flush),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_data      (dec),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_data      (out)
  );

  assign o_alu_op  = out.alu_op;
  assign o_op1     = out.op1;
  assign o_op2     = out.op2;
  assign o_rd_addr = out.rd_addr;
  assign o_rd_we   = out.rd_we;
  assign o_pc      = out.pc;
  assign o_illegal = out.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage (REG_READY=1): directed RV32I cases, stall/flush/reset, then random traffic.
`timescale 1ns/1ps
module tb_decode_stage;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] instr = '0, pc_s = '0, rs1 = '0, rs2 = '0;
  logic        o_in_ready, o_out_valid, o_rd_we, o_illegal;
  logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
  logic [31:0] o_op1, o_op2, o_pc;
  alu_opcode_t o_alu_op;

  always #5 clk = ~clk;

  decode_stage #(.REG_READY(1'b1)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
    .i_in_valid(in_valid), .o_in_ready(o_in_ready),
    .i_instr(instr), .i_pc(pc_s),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .i_rs1_data(rs1), .i_rs2_data(rs2),
    .o_out_valid(o_out_valid), .i_out_ready(out_ready),
    .o_alu_op(o_alu_op), .o_op1(o_op1), .o_op2(o_op2),
    .o_rd_addr(o_rd_addr), .o_rd_we(o_rd_we), .o_pc(o_pc), .o_illegal(o_illegal)
  );

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  int n_xfer = 0;
  int held   = 0;
  decoded_t exp_q[$];

  localparam alu_opcode_t BASE_OPS [8] =
    '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference decode straight from the ISA rules.
  function automatic decoded_t ref_model(input logic [31:0] ins, input logic [31:0] pc,
                                         input logic [31:0] a, input logic [31:0] b);
    decoded_t r;
    logic [6:0] f7;
    logic [2:0] f3;
    logic ok;
    f7 = ins[31:25];
    f3 = ins[14:12];
    r = '0;
    r.pc = pc;
    r.rd_addr = ins[11:7];
    r.alu_op = ALU_ADD;
    ok = 1'b0;
    if (ins[6:0] == 7'h33) begin
      ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      r.alu_op = BASE_OPS[f3];
      if (f7 == 7'h20) r.alu_op = (f3 == 3'd0) ? ALU_SUB : ALU_SRA;
      r.op1 = a;
      r.op2 = b;
    end else if (ins[6:0] == 7'h13) begin
      r.op1 = a;
      if (f3 == 3'd1 || f3 == 3'd5) r.op2 = 32'(ins[24:20]);
      else r.op2 = 32'($signed(ins[31:20]));
      if (f3 == 3'd1) ok = (f7 == 7'h00);
      else if (f3 == 3'd5) ok = (f7 == 7'h00 || f7 == 7'h20);
      else ok = 1'b1;
      r.alu_op = (f3 == 3'd5 && f7 == 7'h20) ? ALU_SRA : BASE_OPS[f3];
    end else if (ins[6:0] == 7'h37 || ins[6:0] == 7'h17) begin
      ok = 1'b1;
      r.op1 = (ins[6:0] == 7'h17) ? pc : 32'd0;
      r.op2 = ins & 32'hFFFF_F000;
    end
    if (!ok) begin
      r.alu_op = ALU_ADD;
      r.op1 = 0;
      r.op2 = 0;
    end
    r.illegal = !ok;
    r.rd_we = ok && (r.rd_addr != 0);
    return r;
  endfunction

  function automatic decoded_t dut_bundle();
    decoded_t g;
    g.alu_op = o_alu_op; g.op1 = o_op1; g.op2 = o_op2; g.rd_addr = o_rd_addr;
    g.rd_we = o_rd_we; g.pc = o_pc; g.illegal = o_illegal;
    return g;
  endfunction

  // Input side: occupancy model, ready/valid expectations, push expected bundles.
  always @(negedge clk) begin
    if (!rst_n) begin
      held = 0;
      exp_q.delete();
    end else begin
      bit acc, xfer;
      chk("in_ready", o_in_ready, held < 2);
      chk("out_valid", o_out_valid, held > 0);
      acc  = in_valid && (held < 2) && !flush;
      xfer = (held > 0) && out_ready && !flush;
      if (flush) begin
        held = 0;
        exp_q.delete();
      end else begin
        if (acc) begin
          exp_q.push_back(ref_model(instr, pc_s, rs1, rs2));
          n_acc++;
        end
        held = held + int'(acc) - int'(xfer);
      end
    end
  end

  // Output side: pop and compare on transfer, stability while stalled.
  decoded_t prev;
  bit       have_prev = 0;
  always @(negedge clk) begin
    if (!rst_n || flush) begin
      have_prev = 0;
    end else begin
      decoded_t got;
      got = dut_bundle();
      if (have_prev) begin
        checks++;
        if (!o_out_valid || got !== prev) begin
          errors++;
          $display("FAIL stall_stable: got vld=%b %h expected vld=1 %h", o_out_valid, got, prev);
        end
      end
      have_prev = 0;
      if (o_out_valid && !out_ready) begin
        prev = got;
        have_prev = 1;
      end else if (o_out_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: got %h expected no output", got);
        end else begin
          decoded_t e;
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL bundle: got op=%0d op1=%h op2=%h rd=%0d we=%b pc=%h ill=%b expected op=%0d op1=%h op2=%h rd=%0d we=%b pc=%h ill=%b",
                     got.alu_op, got.op1, got.op2, got.rd_addr, got.rd_we, got.pc, got.illegal,
                     e.alu_op, e.op1, e.op2, e.rd_addr, e.rd_we, e.pc, e.illegal);
          end
        end
        n_xfer++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input string nm, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b, input alu_opcode_t eop,
                         input logic [31:0] e1, input logic [31:0] e2, input logic [4:0] erd,
                         input logic ewe, input logic eill);
    instr = ins; pc_s = pc; rs1 = a; rs2 = b; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({nm, "_rs1a"}, o_rs1_addr, ins[19:15]);
    chk({nm, "_rs2a"}, o_rs2_addr, ins[24:20]);
    cyc();
    in_valid = 1'b0;
    chk({nm, "_vld"}, o_out_valid, 1);
    chk({nm, "_op"}, o_alu_op, eop);
    chk({nm, "_op1"}, o_op1, e1);
    chk({nm, "_op2"}, o_op2, e2);
    chk({nm, "_rd"}, o_rd_addr, erd);
    chk({nm, "_we"}, o_rd_we, ewe);
    chk({nm, "_ill"}, o_illegal, eill);
    cyc();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] w;
    logic [6:0]  f7;
    w = $urandom;
    case ($urandom_range(0, 3))
      0, 1:    f7 = 7'h00;
      2:       f7 = 7'h20;
      default: f7 = 7'($urandom);
    endcase
    case ($urandom_range(0, 5))
      0, 1: begin w[6:0] = OPC_OP;     w[31:25] = f7; end
      2:    begin w[6:0] = OPC_OP_IMM; if ($urandom_range(0, 1) == 1) w[31:25] = f7; end
      3:    w[6:0] = OPC_LUI;
      4:    w[6:0] = OPC_AUIPC;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, x0;
    cyc(); cyc();
    chk("rst_vld", o_out_valid, 0);
    chk("rst_rdy", o_in_ready, 1);
    chk("rst_op", o_alu_op, ALU_ADD);
    chk("rst_op1", o_op1, 0);
    chk("rst_pc", o_pc, 0);
    rst_n = 1'b1;
    cyc();

    run_one("addi",   32'h0050_0093, 32'h0,   32'd0,  32'd0, ALU_ADD, 0, 5, 1, 1, 0);
    run_one("sub",    32'h4020_81B3, 32'h4,   32'd10, 32'd3, ALU_SUB, 10, 3, 3, 1, 0);
    run_one("srai",   32'h4042_D293, 32'h8,   32'h8000_0000, 32'd7, ALU_SRA, 32'h8000_0000, 4, 5, 1, 0);
    run_one("auipc",  32'h1234_5097, 32'h100, 32'd9,  32'd9, ALU_ADD, 32'h100, 32'h1234_5000, 1, 1, 0);
    run_one("mul",    32'h0220_8033, 32'h10,  32'd1,  32'd2, ALU_ADD, 0, 0, 0, 0, 1);
    run_one("opc7f",  32'h0000_057F, 32'h14,  32'd1,  32'd2, ALU_ADD, 0, 0, 10, 0, 1);
    run_one("addix0", 32'h0050_0013, 32'h18,  32'd1,  32'd2, ALU_ADD, 1, 5, 0, 0, 0);
    run_one("addineg",32'hFFF0_8113, 32'h1C,  32'd7,  32'd0, ALU_ADD, 7, 32'hFFFF_FFFF, 2, 1, 0);

    // Stall: three back-to-back offers with execute blocked.
    out_ready = 1'b0;
    n0 = n_acc;
    for (int i = 1; i <= 3; i++) begin
      instr = 32'h0000_0093 | (32'(i) << 20) | (32'(i) << 7);
      pc_s = 32'h200 + 32'(4 * i); rs1 = 32'(i); in_valid = 1'b1;
      #1;
      chk("stall_rdy", o_in_ready, i < 3);
      if (i < 3) cyc();
    end
    cyc(); cyc();
    chk("stall_acc", n_acc - n0, 2);
    chk("stall_vld", o_out_valid, 1);
    out_ready = 1'b1;
    for (int t = 0; t < 10 && !o_in_ready; t++) cyc();
    chk("stall_rel_rdy", o_in_ready, 1);
    cyc();
    in_valid = 1'b0;
    for (int t = 0; t < 5; t++) cyc();
    chk("stall_acc3", n_acc - n0, 3);
    chk("stall_drain", exp_q.size(), 0);

    // Flush with two entries held, offer in the flush cycle dropped.
    out_ready = 1'b0;
    in_valid = 1'b1; instr = 32'h0010_0093; cyc();
    instr = 32'h0020_0113; cyc();
    n0 = n_acc; x0 = n_xfer;
    flush = 1'b1; instr = 32'h0030_0193; out_ready = 1'b1; cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_vld", o_out_valid, 0);
    chk("flush_rdy", o_in_ready, 1);
    for (int t = 0; t < 5; t++) cyc();
    chk("flush_acc", n_acc - n0, 0);
    chk("flush_none", n_xfer - x0, 0);

    // Asynchronous reset with a bundle pending.
    out_ready = 1'b0; in_valid = 1'b1; instr = 32'h0123_4537; pc_s = 32'h300; cyc();
    in_valid = 1'b0;
    chk("prerst_vld", o_out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_vld", o_out_valid, 0);
    chk("arst_rdy", o_in_ready, 1);
    chk("arst_op", o_alu_op, ALU_ADD);
    chk("arst_op2", o_op2, 0);
    chk("arst_rd", o_rd_addr, 0);
    chk("arst_pc", o_pc, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    cyc();

    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      instr = gen_instr();
      pc_s = $urandom & 32'hFFFF_FFFC;
      rs1 = $urandom;
      rs2 = $urandom;
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int t = 0; t < 10; t++) cyc();
    chk("final_drain", exp_q.size(), 0);
    chk("final_vld", o_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
